// File: rtl/xor_stream_acc.sv
// Frame XOR accumulator: folds a last-framed word stream into one XOR word.
// Each frame's result (word, parity, saturating count) leaves via a valid/ready handshake.
module xor_stream_acc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             load_c;

    logic             accept_c;
    logic             handshake_c;
    logic             cnt_sat_c;
    logic [WIDTH-1:0] acc_x_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             ovf_inc_c;

    // Value of the running frame state if the current word is folded in
    assign accept_c    = in_valid & in_ready;
    assign handshake_c = out_valid & out_ready;
    assign cnt_sat_c   = (cnt_q == CNT_MAX);
    assign acc_x_c     = acc_q ^ in_data;
    assign cnt_inc_c   = cnt_sat_c ? cnt_q : cnt_q + CNT_W'(1);
    assign ovf_inc_c   = ovf_q | cnt_sat_c;

    // Next-state and accumulator update; clr overrides everything but rst
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        load_c  = 1'b0;
        if (clr) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept_c) begin
                        if (in_last) begin
                            load_c  = 1'b1;
                            state_d = ST_OUT;
                            acc_d   = '0;
                            cnt_d   = '0;
                            ovf_d   = 1'b0;
                        end else begin
                            acc_d = acc_x_c;
                            cnt_d = cnt_inc_c;
                            ovf_d = ovf_inc_c;
                        end
                    end
                end
                ST_OUT: begin
                    if (handshake_c) begin
                        state_d = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    // State, accumulator and registered outputs; result fields only change on load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_parity <= 1'b0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            in_ready  <= (state_d == ST_ACC);
            out_valid <= (state_d == ST_OUT);
            if (load_c) begin
                out_data   <= acc_x_c;
                out_parity <= ^acc_x_c;
                out_count  <= cnt_inc_c;
                out_ovf    <= ovf_inc_c;
            end
        end
    end

endmodule

// File: tb/tb_xor_stream_acc.sv
// Directed bench for xor_stream_acc: an 8-bit/2-bit-count instance for framing,
// saturation, backpressure, clr and reset, plus a 1-bit instance for the XOR truth table.
module tb_xor_stream_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: WIDTH=8, CNT_W=2
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_parity;
    logic [1:0] out_count;
    logic       out_ovf;

    xor_stream_acc #(.WIDTH(8), .CNT_W(2)) u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity(out_parity), .out_count(out_count), .out_ovf(out_ovf)
    );

    // 1-bit instance
    logic       b_clr = 1'b0;
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [0:0] b_in_data = '0;
    logic       b_in_last = 1'b0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b1;
    logic [0:0] b_out_data;
    logic       b_out_parity;
    logic [7:0] b_out_count;
    logic       b_out_ovf;

    xor_stream_acc #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .clr(b_clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_parity(b_out_parity), .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int unsigned n;
        logic [39:0] w;
        logic [7:0]  e_data;
        logic        e_par;
        logic [1:0]  e_cnt;
        logic        e_ovf;
    } frame_t;

    typedef struct {
        logic a;
        logic b;
        logic e;
    } bit_row_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send_word(input logic [7:0] d, input logic last);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_result(input string nm, input logic [7:0] d, input logic p,
                              input logic [1:0] c, input logic o);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({nm, "_data"}, 32'(out_data), 32'(d));
        chk({nm, "_parity"}, 32'(out_parity), 32'(p));
        chk({nm, "_count"}, 32'(out_count), 32'(c));
        chk({nm, "_ovf"}, 32'(out_ovf), 32'(o));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t   ft[6];
        bit_row_t bt[4];

        ft[0] = '{n: 3, w: 40'h00_00_3C_F0_0F, e_data: 8'hC3, e_par: 1'b0, e_cnt: 2'd3, e_ovf: 1'b0};
        ft[1] = '{n: 1, w: 40'h00_00_00_00_A5, e_data: 8'hA5, e_par: 1'b0, e_cnt: 2'd1, e_ovf: 1'b0};
        ft[2] = '{n: 5, w: 40'h01_01_01_01_01, e_data: 8'h01, e_par: 1'b1, e_cnt: 2'd3, e_ovf: 1'b1};
        ft[3] = '{n: 1, w: 40'h00_00_00_00_01, e_data: 8'h01, e_par: 1'b1, e_cnt: 2'd1, e_ovf: 1'b0};
        ft[4] = '{n: 2, w: 40'h00_00_00_01_FF, e_data: 8'hFE, e_par: 1'b1, e_cnt: 2'd2, e_ovf: 1'b0};
        ft[5] = '{n: 4, w: 40'h00_10_20_40_80, e_data: 8'hF0, e_par: 1'b0, e_cnt: 2'd3, e_ovf: 1'b1};

        bt[0] = '{a: 1'b0, b: 1'b0, e: 1'b0};
        bt[1] = '{a: 1'b0, b: 1'b1, e: 1'b1};
        bt[2] = '{a: 1'b1, b: 1'b1, e: 1'b0};
        bt[3] = '{a: 1'b1, b: 1'b0, e: 1'b1};

        // Reset state
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_parity", 32'(out_parity), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        step();
        rst = 1'b0;
        chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        step();
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Table-driven frames, out_ready held high
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < int'(ft[i].n); j++)
                send_word(ft[i].w[8*j +: 8], (j == int'(ft[i].n) - 1));
            chk_result($sformatf("frame%0d", i), ft[i].e_data, ft[i].e_par, ft[i].e_cnt, ft[i].e_ovf);
            step();
            chk($sformatf("frame%0d_valid_drop", i), 32'(out_valid), 32'd0);
            chk($sformatf("frame%0d_ready_back", i), 32'(in_ready), 32'd1);
        end

        // Backpressure; producer pushes a word during OUT that must be ignored
        out_ready = 1'b0;
        send_word(8'hA5, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk_result($sformatf("bp%0d", k), 8'hA5, 1'b0, 2'd1, 1'b0);
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_data_retained", 32'(out_data), 32'hA5);

        // in_last without in_valid has no effect
        in_last = 1'b1;
        in_data = 8'h99;
        step();
        in_last = 1'b0;
        chk("stray_last_no_valid", 32'(out_valid), 32'd0);
        send_word(8'h3C, 1'b1);
        chk_result("after_stray_last", 8'h3C, 1'b0, 2'd1, 1'b0);
        step();

        // clr mid-frame discards accumulation and the concurrent word
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h44;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        send_word(8'h08, 1'b1);
        chk_result("after_clr", 8'h08, 1'b1, 2'd1, 1'b0);
        step();

        // clr during OUT drops the pending result even with out_ready high
        out_ready = 1'b0;
        send_word(8'h77, 1'b1);
        chk("clr_out_pending", 32'(out_valid), 32'd1);
        clr       = 1'b1;
        out_ready = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_out_valid_drop", 32'(out_valid), 32'd0);
        chk("clr_out_in_ready", 32'(in_ready), 32'd1);
        chk("clr_out_data_kept", 32'(out_data), 32'h77);
        step();
        chk("clr_out_stays_low", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges mid-frame
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_parity", 32'(out_parity), 32'd0);
        chk("arst_out_count", 32'(out_count), 32'd0);
        chk("arst_out_ovf", 32'(out_ovf), 32'd0);
        step();
        rst = 1'b0;
        step();
        send_word(8'h55, 1'b1);
        chk_result("after_arst", 8'h55, 1'b0, 2'd1, 1'b0);
        step();

        // 1-bit instance: two-word frames reproduce the XOR truth table
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("bit%0d_in_ready", r), 32'(b_in_ready), 32'd1);
            b_in_valid = 1'b1;
            b_in_data  = bt[r].a;
            b_in_last  = 1'b0;
            step();
            b_in_data = bt[r].b;
            b_in_last = 1'b1;
            step();
            b_in_valid = 1'b0;
            b_in_last  = 1'b0;
            chk($sformatf("bit%0d_valid", r), 32'(b_out_valid), 32'd1);
            chk($sformatf("bit%0d_data", r), 32'(b_out_data), 32'(bt[r].e));
            chk($sformatf("bit%0d_parity", r), 32'(b_out_parity), 32'(bt[r].e));
            chk($sformatf("bit%0d_count", r), 32'(b_out_count), 32'd2);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xor_stream_acc.md
Name: xor_stream_acc

Overview:
- Parametrised, clocked successor to the team's 2-input XOR primitive.
- Accepts a stream of WIDTH-bit words framed by a last flag, and accumulates their bitwise XOR across the frame.
- Once per frame it presents the XOR word, its parity bit and the word count through a valid/ready output handshake.
- Used as a frame checksum/parity stage between stream producers and consumers.

Parameters:
WIDTH, 8, data word width in bits (>=1)
CNT_W, 8, width of the per-frame word counter (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous clear: drop accumulation and any pending result
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_data  input  WIDTH  input word
in_last  input  1  marks final word of frame (qualified by in_valid)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  XOR of all words in frame
out_parity  output  1  reduction XOR of out_data
out_count  output  CNT_W  number of words in frame (saturating)
out_ovf  output  1  frame exceeded 2^CNT_W-1 words

Behaviour:
- Reset and interface:
  - Reset is asynchronous and active-high; clock is single.
  - On rst, all outputs are 0 immediately: in_ready=0, out_valid=0, out_data=0, out_parity=0, out_count=0, out_ovf=0.
  - Internally the block enters ACC with accumulator=0 and count=0.
  - in_ready goes to 1 on the first clock edge after rst deasserts.
- State machine has two states, ACC and OUT.
- ACC state:
  - in_ready=1 and out_valid=0.
  - A word is accepted when in_valid & in_ready at a clock edge.
  - On accept: acc <= acc ^ in_data.
  - On accept: count <= count+1, saturating at 2^CNT_W-1. An increment attempted at saturation sets a sticky ovf flag for the frame.
  - Accept with in_last=1: out_data <= acc ^ in_data, out_count <= final count, out_ovf <= final ovf, out_parity <= ^(acc ^ in_data). The block then moves to OUT.
  - acc, count and ovf clear in the same edge as the accept with in_last=1.
- OUT state:
  - in_ready=0 and out_valid=1.
  - Output fields are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready at a clock edge: out_valid=0, in_ready=1, and the block returns to ACC.
  - out_data, out_count, out_parity and out_ovf retain their last values after out_valid drops.
- Latency and throughput:
  - out_valid rises on the edge that accepts the last word, so it is visible the cycle after the last beat.
  - Minimum frame period is (words + 1) cycles: one bubble per frame for the output handshake.
- Single-word frame (in_last on first word): out_data=in_data, out_count=1.
- clr (synchronous, highest priority after rst):
  - At the next edge: acc=0, count=0, ovf=0, out_valid=0, and the block returns to ACC.
  - A word presented in the same cycle as clr is discarded.
  - A pending result is discarded even if out_ready=1 in that cycle.
  - Output data fields are not zeroed.
- Simultaneous events:
  - in_valid in OUT is ignored (in_ready=0); the producer must hold.
  - in_last without in_valid has no effect.
  - rst mid-frame or mid-OUT aborts everything with no partial result emitted.
- Arithmetic:
  - All XOR is bitwise over WIDTH bits.
  - The count is unsigned CNT_W bits and never wraps.

Test Plan:
1. Reset then frame: WIDTH=8 words 0x0F, 0xF0, 0x3C with last on 0x3C, out_ready=1 -> out_data=0xC3, out_parity=0, out_count=3, out_valid for exactly 1 cycle, one cycle after the last accept.
2. Backpressure: frame 0xA5 (last), out_ready=0 for 5 cycles -> out_valid held, in_ready=0, out_data=0xA5, out_parity=0, out_count=1 stable. Then out_ready=1 -> ACC on the next edge.
3. Exhaustive 1-bit (WIDTH=1): two-word frames (a,b) over 00/01/11/10 -> out_data = 0, 1, 0, 1, matching a 2-input XOR truth table.
4. Saturation: CNT_W=2, a frame of 5 words of 0x01 -> out_count=3, out_ovf=1, out_data=0x01. The next frame of 1 word -> out_ovf=0, out_count=1.
5. clr: accept 0x11, 0x22, then clr together with in_valid 0x44, then frame 0x08 (last) -> out_data=0x08, out_count=1. A second run asserts clr during OUT -> out_valid drops next edge and the result is never handshaked.
6. Async reset mid-frame: rst asserted between clock edges after 2 words -> outputs are 0 before the next edge. A subsequent frame 0x55 (last) -> out_data=0x55, out_count=1.
